// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs four ADS sample streams into 64-bit frames and buffers them in a FWFT FIFO.
// Define PACKER_TIMESTAMP_EN to insert RTC timing words ahead of every FRAMES_PER_STAMP-th data frame.
module adc_frame_packer #(
  parameter int FRAMES_PER_STAMP = 256,
  parameter int TIMEOUT          = 1023,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ds_MsecondsL,
  input  logic [7:0]  ds_MsecondsH,
  input  logic [7:0]  ds_Seconds,
  input  logic [7:0]  ds_Minutes,
  input  logic [7:0]  ds_Hour,
  input  logic [7:0]  ds_Date,
  input  logic [7:0]  ds_Month,
  input  logic [7:0]  ds_Year,
  input  logic [15:0] Ch0_Dataf_ads1,
  input  logic [15:0] Ch1_Dataf_ads1,
  input  logic [15:0] Ch0_Dataf_ads2,
  input  logic [15:0] Ch1_Dataf_ads2,
  input  logic        Ch0_Dataf_en_ads1,
  input  logic        Ch1_Dataf_en_ads1,
  input  logic        Ch0_Dataf_en_ads2,
  input  logic        Ch1_Dataf_en_ads2,
  output logic [63:0] out_dat,
  output logic        out_is_timing,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pkg_num,
  output logic [3:0]  missing_flags,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [16:0]   TIMEOUT_C = 17'(TIMEOUT);
`ifdef PACKER_TIMESTAMP_EN
  localparam int WW = 65;
  localparam logic [15:0] FPS_LAST = 16'(FRAMES_PER_STAMP - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, STAMP, DATA} state_t;
`else
  localparam int WW = 64;
  typedef enum logic [1:0] {IDLE, COLLECT, DATA} state_t;
`endif

  generate
    if (FRAMES_PER_STAMP < 1 || FRAMES_PER_STAMP > 65535 || TIMEOUT < 1 || TIMEOUT > 65535 ||
        FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("adc_frame_packer: parameter out of range");
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [15:0]   sample [4];
  logic [15:0]   hold_reg [4];
  logic [3:0]    en, got_reg, have;
  logic [16:0]   tcnt_reg;
  logic [63:0]   data_reg, frame_next;
  logic          frame_start, collecting, complete, timed_out, emit, stamp_due, accept, drop;
  logic [CW-1:0] need, count_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic          push, push_data, pop;
  logic [WW-1:0] push_word, head;
  logic [WW-1:0] mem [FIFO_DEPTH];

  assign sample[0] = Ch0_Dataf_ads1;
  assign sample[1] = Ch1_Dataf_ads1;
  assign sample[2] = Ch0_Dataf_ads2;
  assign sample[3] = Ch1_Dataf_ads2;
  assign en = {Ch1_Dataf_en_ads2, Ch0_Dataf_en_ads2, Ch1_Dataf_en_ads1, Ch0_Dataf_en_ads1};

  // Enables seen in the emit cycle still belong to the frame being emitted.
  assign have        = got_reg | en;
  assign frame_start = (got_reg == 4'h0) && (en != 4'h0);
  assign collecting  = (state_reg == IDLE) || (state_reg == COLLECT);
  assign complete    = (have == 4'hF);
  assign timed_out   = (state_reg == COLLECT) && ((tcnt_reg + 17'd1) >= TIMEOUT_C);
  assign emit        = collecting && (complete || timed_out);
  assign need        = stamp_due ? CW'(2) : CW'(1);
  assign accept      = emit && ((DEPTH_C - count_reg) >= need);
  assign drop        = emit && !accept;
  assign push_data   = (state_reg == DATA);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_reg[gi] <= 16'h0;
        end else if (en[gi]) begin
          hold_reg[gi] <= sample[gi];
        end
      end
      assign frame_next[16*gi +: 16] = !have[gi] ? 16'h8000 : (en[gi] ? sample[gi] : hold_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, COLLECT: begin
        if (emit) begin
          if (!accept) begin
            state_next = IDLE;
`ifdef PACKER_TIMESTAMP_EN
          end else if (stamp_due) begin
            state_next = STAMP;
`endif
          end else begin
            state_next = DATA;
          end
        end else if (have != 4'h0) begin
          state_next = COLLECT;
        end else begin
          state_next = IDLE;
        end
      end
`ifdef PACKER_TIMESTAMP_EN
      STAMP:   state_next = DATA;
`endif
      DATA:    state_next = (have != 4'h0) ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef PACKER_TIMESTAMP_EN
  logic [63:0] live_time, time_reg, stamp_reg;
  logic [15:0] frame_cnt_reg;

  assign live_time = {ds_Year, ds_Month, ds_Date, ds_Hour, ds_Minutes, ds_Seconds, ds_MsecondsH, ds_MsecondsL};
  assign stamp_due = (frame_cnt_reg == 16'd0);

  always_comb begin
    push      = 1'b0;
    push_word = {1'b0, data_reg};
    case (state_reg)
      STAMP: begin
        push      = 1'b1;
        push_word = {1'b1, stamp_reg};
      end
      DATA:    push = 1'b1;
      default: push = 1'b0;
    endcase
  end

  // A frame that starts and completes in the same cycle must stamp the live time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_reg      <= 64'h0;
      stamp_reg     <= 64'h0;
      frame_cnt_reg <= 16'h0;
    end else begin
      if (frame_start) time_reg <= live_time;
      if (emit) stamp_reg <= frame_start ? live_time : time_reg;
      if (push_data) frame_cnt_reg <= (frame_cnt_reg == FPS_LAST) ? 16'h0 : frame_cnt_reg + 16'h1;
    end
  end

  assign out_is_timing = out_valid & head[64];
`else
  logic unused_time;
  assign unused_time = ^{ds_Year, ds_Month, ds_Date, ds_Hour, ds_Minutes, ds_Seconds, ds_MsecondsH, ds_MsecondsL};
  assign stamp_due   = 1'b0;

  always_comb begin
    push      = push_data;
    push_word = data_reg;
  end

  assign out_is_timing = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got_reg       <= 4'h0;
      tcnt_reg      <= 17'h0;
      data_reg      <= 64'h0;
      missing_flags <= 4'h0;
      pkg_num       <= 8'h0;
      overflow      <= 1'b0;
    end else begin
      got_reg  <= emit ? 4'h0 : have;
      tcnt_reg <= (emit || got_reg == 4'h0) ? 17'h0 : tcnt_reg + 17'h1;
      if (emit) begin
        data_reg      <= frame_next;
        missing_flags <= ~have;
      end
      if (push_data) pkg_num <= pkg_num + 8'h1;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Space is reserved at emit, so a push never lands on a full FIFO unless a pop frees it.
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign out_valid = (count_reg != '0);
  assign head      = mem[rd_ptr_reg];
  assign out_dat   = out_valid ? head[63:0] : 64'h0;

endmodule
